gambit_tlb: RTL and testbench
=============================

GAMBIT_TLB -- requirements
Module: gambit_tlb

Interface
REQ-001 Parameter ENTRIES, default 8 (power of two, 2..32); number of fully-associative translation entries.
REQ-002 Single clock, synchronous active-high reset; ports named clk and rst as elsewhere in the CPU.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cyc_i, stb_i, we_i  in  1 each  CPU request; icl_i  in  1  instruction fetch; ol_i  in  2  operating level; sel_i  in  8  byte lanes.
REQ-006 vadr_i  in  52  virtual address; ASID=[51:44], VPN=[31:13], offset=[12:0].
REQ-007 ack_o, err_o, rdv_o, wrv_o, exv_o, page_fault_o  out  1 each  CPU completion and fault status.
REQ-008 walk_req_o  out  1  miss request to the inverted-page-table unit; walk_vadr_o  out  52  address being walked.
REQ-009 walk_done_i  in  1  walk result valid; walk_padr_i  in  32  translated address (frame=[31:13]); walk_drwx_i  in  4  {d,r,w,x}; walk_fault_i  in  1  no mapping.
REQ-010 cyc_o, we_o  out  1  physical bus cycle; sel_o  out  8; padr_o  out  32; ack_i  in  1.
REQ-011 inv_all_i  in  1  flush all entries; inv_asid_i  in  1 with inv_asid_v_i  in  8  flush entries of one ASID.

Function
REQ-012 States: IDLE, WALK, BUS, VIOL, WAIT.
REQ-013 Bypass (no lookup, padr_o=vadr_i[31:0]) when ol_i==0 or vadr_i[31:24]==8'hFF or 8'h00.
REQ-014 IDLE, cyc_i&stb_i: hit = valid & ASID match & VPN match, compared combinationally; hit or bypass -> BUS next cycle with cyc_o=1, padr_o={frame,vadr_i[12:0]}, we_o=we_i, sel_o=sel_i.
REQ-015 Hit with permission failure (~r&~we_i -> rdv_o, ~w&we_i -> wrv_o, ~x&icl_i -> exv_o) -> VIOL; no bus cycle.
REQ-016 Miss -> WALK; walk_req_o=1 and walk_vadr_o held stable until walk_done_i.
REQ-017 WALK, walk_done_i&walk_fault_i -> page_fault_o=1 one cycle, ack_o=1, err_o=1, go WAIT; no fill.
REQ-018 WALK, walk_done_i&~walk_fault_i -> fill entry, then apply REQ-014/015 permission check on walk data the following cycle.
REQ-019 Victim: lowest-index invalid entry; else round-robin pointer, incremented on each fill, wrapping ENTRIES-1 -> 0.
REQ-020 BUS: hold cyc_o until ack_i; on ack_i drive ack_o one cycle, drop cyc_o/we_o, go WAIT.
REQ-021 VIOL: ack_o=1, err_o=1, violation flag(s) one cycle, go WAIT.
REQ-022 WAIT: return to IDLE when stb_i=0; no new request accepted while in WAIT.
REQ-023 Latency: hit/bypass cyc_o 1 cycle after request; miss cyc_o 2 cycles after walk_done_i.
REQ-024 Invalidate applies in any state the cycle it is asserted; inv_all_i and inv_asid_i together act as inv_all_i.
REQ-025 Invalidate in the same cycle as walk_done_i: current access completes using walk data, fill suppressed.
REQ-026 cyc_i dropped in WALK: wait for walk_done_i, fill, return to IDLE without a bus cycle.

Reset
REQ-027 rst clears all valid bits, round-robin pointer=0, state=IDLE.
REQ-028 All outputs 0 after reset, padr_o=32'h0, walk_vadr_o=52'h0.
REQ-029 Reset mid-WALK or mid-BUS abandons the operation immediately; late walk_done_i/ack_i in IDLE ignored.

Structure
REQ-030 Shared package gambit_tlb_pkg: state enum, entry struct {valid, asid[7:0], vpn[18:0], frame[18:0], drwx[3:0]}, bypass region constants 8'hFF/8'h00.
REQ-031 One sub-module gambit_tlb_cam: entry storage, parallel match, hit index, invalidate and fill ports.

Verification
REQ-032 Bypass: ol_i=0, vadr_i=52'h0_0012_3456 -> cyc_o next cycle, padr_o=32'h0012_3456, no walk_req_o.
REQ-033 Miss then hit: ASID 8'h05, vadr[31:0]=32'h1000_2010, walk_padr_i=32'h0004_A000, drwx=4'b0110 -> padr_o=32'h0004_A010; repeat -> no walk, cyc_o after 1 cycle.
REQ-034 Write to drwx=4'b0100 entry -> wrv_o=1, err_o=1, ack_o=1, cyc_o never asserted.
REQ-035 walk_fault_i=1 -> page_fault_o one cycle, err_o=1, no fill (next access to same address walks again).
REQ-036 Fill 9 distinct pages with ENTRIES=8 -> entry 0 evicted, pointer=1; inv_asid_i with 8'h05 -> all ASID-5 accesses miss.
REQ-037 rst asserted during WALK -> state IDLE, all outputs 0 next cycle, subsequent walk_done_i ignored.

Source files
------------

// File: rtl/gambit_tlb_pkg.sv
// gambit_tlb shared types and constants.
// Entry layout, FSM states and bypass regions.
package gambit_tlb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALK,
        S_BUS,
        S_VIOL,
        S_WAIT
    } tlb_state_e;

    typedef struct packed {
        logic        valid;
        logic [7:0]  asid;
        logic [18:0] vpn;
        logic [18:0] frame;
        logic [3:0]  drwx;
    } tlb_entry_t;

    localparam logic [7:0] BYP_HI = 8'hFF;
    localparam logic [7:0] BYP_LO = 8'h00;

    localparam int D_B = 3;
    localparam int R_B = 2;
    localparam int W_B = 1;
    localparam int X_B = 0;

    function automatic logic is_bypass(
        input logic [1:0]  ol,
        input logic [51:0] va
    );
        return (ol == 2'd0)
            || (va[31:24] == BYP_HI)
            || (va[31:24] == BYP_LO);
    endfunction

endpackage

// File: rtl/gambit_tlb_cam.sv
// gambit_tlb entry store: parallel match,
// victim choice, fill and invalidate.
module gambit_tlb_cam
    import gambit_tlb_pkg::*;
#(
    parameter int ENTRIES = 8,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    lk_asid_i,
    input  logic [18:0]   lk_vpn_i,
    output logic          hit_o,
    output logic [IW-1:0] hit_idx_o,
    output logic [18:0]   hit_frame_o,
    output logic [3:0]    hit_drwx_o,
    input  logic          fill_i,
    input  logic [7:0]    fill_asid_i,
    input  logic [18:0]   fill_vpn_i,
    input  logic [18:0]   fill_frame_i,
    input  logic [3:0]    fill_drwx_i,
    input  logic          inv_all_i,
    input  logic          inv_asid_i,
    input  logic [7:0]    inv_asid_v_i
);

    tlb_entry_t    ent_q [ENTRIES];
    logic [IW-1:0] rr_q;
    logic [IW-1:0] victim;
    logic          vfound;

    // Lowest-index matching entry wins.
    always_comb begin
        hit_o       = 1'b0;
        hit_idx_o   = '0;
        hit_frame_o = '0;
        hit_drwx_o  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit_o && ent_q[i].valid
                && ent_q[i].asid == lk_asid_i
                && ent_q[i].vpn == lk_vpn_i) begin
                hit_o       = 1'b1;
                hit_idx_o   = IW'(i);
                hit_frame_o = ent_q[i].frame;
                hit_drwx_o  = ent_q[i].drwx;
            end
        end
    end

    // Prefer the lowest free slot, else round-robin.
    always_comb begin
        victim = rr_q;
        vfound = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!vfound && !ent_q[i].valid) begin
                victim = IW'(i);
                vfound = 1'b1;
            end
        end
    end

    // Entry storage, invalidate and fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (inv_all_i || (inv_asid_i
                    && ent_q[i].asid == inv_asid_v_i)) begin
                    ent_q[i].valid <= 1'b0;
                end
            end
            if (fill_i) begin
                ent_q[victim] <= '{
                    valid: 1'b1,
                    asid:  fill_asid_i,
                    vpn:   fill_vpn_i,
                    frame: fill_frame_i,
                    drwx:  fill_drwx_i
                };
                rr_q <= rr_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/gambit_tlb.sv
// gambit_tlb top: request FSM, permission
// checks, walk handshake and bus cycle.
module gambit_tlb
    import gambit_tlb_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic        icl_i,
    input  logic [1:0]  ol_i,
    input  logic [7:0]  sel_i,
    input  logic [51:0] vadr_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rdv_o,
    output logic        wrv_o,
    output logic        exv_o,
    output logic        page_fault_o,
    output logic        walk_req_o,
    output logic [51:0] walk_vadr_o,
    input  logic        walk_done_i,
    input  logic [31:0] walk_padr_i,
    input  logic [3:0]  walk_drwx_i,
    input  logic        walk_fault_i,
    output logic        cyc_o,
    output logic        we_o,
    output logic [7:0]  sel_o,
    output logic [31:0] padr_o,
    input  logic        ack_i,
    input  logic        inv_all_i,
    input  logic        inv_asid_i,
    input  logic [7:0]  inv_asid_v_i
);

    localparam int IW = $clog2(ENTRIES);

    tlb_state_e    state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [7:0]    sel_q, sel_d;
    logic [31:0]   padr_q, padr_d;
    logic          wreq_q, wreq_d;
    logic [51:0]   wva_q, wva_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          rdv_q, rdv_d;
    logic          wrv_q, wrv_d;
    logic          exv_q, exv_d;
    logic          pf_q, pf_d;
    logic          wd_q, wd_d;
    logic [18:0]   wfrm_q, wfrm_d;
    logic [3:0]    wprm_q, wprm_d;

    logic          cam_hit;
    logic [IW-1:0] cam_idx;
    logic [18:0]   cam_frm;
    logic [3:0]    cam_prm;

    logic          req;
    logic          byp;
    logic          hit;
    logic [18:0]   frm;
    logic [3:0]    prm;
    logic          rbad, wbad, xbad;
    logic          inv;
    logic          fill;
    logic          unused_ok;

    assign req  = cyc_i & stb_i;
    assign byp  = is_bypass(ol_i, vadr_i);
    assign hit  = wd_q | cam_hit;
    assign frm  = wd_q ? wfrm_q : cam_frm;
    assign prm  = wd_q ? wprm_q : cam_prm;
    assign rbad = ~prm[R_B] & ~we_i;
    assign wbad = ~prm[W_B] & we_i;
    assign xbad = ~prm[X_B] & icl_i;
    assign inv  = inv_all_i | inv_asid_i;
    assign fill = (state_q == S_WALK) & walk_done_i
                & ~walk_fault_i & ~inv;

    assign unused_ok = ^{walk_padr_i[12:0], cam_idx,
                         vadr_i[43:32], prm[D_B]};

    gambit_tlb_cam #(
        .ENTRIES(ENTRIES)
    ) u_cam (
        .clk          (clk),
        .rst          (rst),
        .lk_asid_i    (vadr_i[51:44]),
        .lk_vpn_i     (vadr_i[31:13]),
        .hit_o        (cam_hit),
        .hit_idx_o    (cam_idx),
        .hit_frame_o  (cam_frm),
        .hit_drwx_o   (cam_prm),
        .fill_i       (fill),
        .fill_asid_i  (wva_q[51:44]),
        .fill_vpn_i   (wva_q[31:13]),
        .fill_frame_i (walk_padr_i[31:13]),
        .fill_drwx_i  (walk_drwx_i),
        .inv_all_i    (inv_all_i),
        .inv_asid_i   (inv_asid_i),
        .inv_asid_v_i (inv_asid_v_i)
    );

    // Next state and registered outputs.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        padr_d  = padr_q;
        wreq_d  = wreq_q;
        wva_d   = wva_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdv_d   = 1'b0;
        wrv_d   = 1'b0;
        exv_d   = 1'b0;
        pf_d    = 1'b0;
        wd_d    = wd_q;
        wfrm_d  = wfrm_q;
        wprm_d  = wprm_q;
        unique case (state_q)
            S_IDLE: begin
                wd_d = 1'b0;
                if (req) begin
                    if (byp) begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        we_d    = we_i;
                        sel_d   = sel_i;
                        padr_d  = vadr_i[31:0];
                    end else if (hit) begin
                        if (rbad | wbad | xbad) begin
                            state_d = S_VIOL;
                            ack_d   = 1'b1;
                            err_d   = 1'b1;
                            rdv_d   = rbad;
                            wrv_d   = wbad;
                            exv_d   = xbad;
                        end else begin
                            state_d = S_BUS;
                            cyc_d   = 1'b1;
                            we_d    = we_i;
                            sel_d   = sel_i;
                            padr_d  = {frm, vadr_i[12:0]};
                        end
                    end else begin
                        state_d = S_WALK;
                        wreq_d  = 1'b1;
                        wva_d   = vadr_i;
                    end
                end
            end
            S_WALK: begin
                if (walk_done_i) begin
                    wreq_d = 1'b0;
                    wva_d  = '0;
                    if (walk_fault_i) begin
                        if (cyc_i) begin
                            state_d = S_WAIT;
                            pf_d    = 1'b1;
                            ack_d   = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_IDLE;
                        wd_d    = 1'b1;
                        wfrm_d  = walk_padr_i[31:13];
                        wprm_d  = walk_drwx_i;
                    end
                end
            end
            S_BUS: begin
                if (ack_i) begin
                    state_d = S_WAIT;
                    ack_d   = 1'b1;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                end
            end
            S_VIOL: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!stb_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            padr_q  <= '0;
            wreq_q  <= 1'b0;
            wva_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            wrv_q   <= 1'b0;
            exv_q   <= 1'b0;
            pf_q    <= 1'b0;
            wd_q    <= 1'b0;
            wfrm_q  <= '0;
            wprm_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            padr_q  <= padr_d;
            wreq_q  <= wreq_d;
            wva_q   <= wva_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
            wrv_q   <= wrv_d;
            exv_q   <= exv_d;
            pf_q    <= pf_d;
            wd_q    <= wd_d;
            wfrm_q  <= wfrm_d;
            wprm_q  <= wprm_d;
        end
    end

    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign rdv_o        = rdv_q;
    assign wrv_o        = wrv_q;
    assign exv_o        = exv_q;
    assign page_fault_o = pf_q;
    assign walk_req_o   = wreq_q;
    assign walk_vadr_o  = wva_q;
    assign cyc_o        = cyc_q;
    assign we_o         = we_q;
    assign sel_o        = sel_q;
    assign padr_o       = padr_q;

endmodule

// File: tb/tb_gambit_tlb.sv
// gambit_tlb directed bench.
// Hand-computed vectors, one checking task.
module tb_gambit_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc_i, stb_i, we_i, icl_i;
    logic [1:0]  ol_i;
    logic [7:0]  sel_i;
    logic [51:0] vadr_i;
    logic        ack_o, err_o, rdv_o, wrv_o, exv_o;
    logic        page_fault_o, walk_req_o;
    logic [51:0] walk_vadr_o;
    logic        walk_done_i, walk_fault_i;
    logic [31:0] walk_padr_i;
    logic [3:0]  walk_drwx_i;
    logic        cyc_o, we_o;
    logic [7:0]  sel_o;
    logic [31:0] padr_o;
    logic        ack_i;
    logic        inv_all_i, inv_asid_i;
    logic [7:0]  inv_asid_v_i;

    logic [8:0]  outs;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign outs = {ack_o, err_o, rdv_o, wrv_o, exv_o,
                   page_fault_o, cyc_o, we_o, walk_req_o};

    gambit_tlb #(
        .ENTRIES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cyc_i        (cyc_i),
        .stb_i        (stb_i),
        .we_i         (we_i),
        .icl_i        (icl_i),
        .ol_i         (ol_i),
        .sel_i        (sel_i),
        .vadr_i       (vadr_i),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .rdv_o        (rdv_o),
        .wrv_o        (wrv_o),
        .exv_o        (exv_o),
        .page_fault_o (page_fault_o),
        .walk_req_o   (walk_req_o),
        .walk_vadr_o  (walk_vadr_o),
        .walk_done_i  (walk_done_i),
        .walk_padr_i  (walk_padr_i),
        .walk_drwx_i  (walk_drwx_i),
        .walk_fault_i (walk_fault_i),
        .cyc_o        (cyc_o),
        .we_o         (we_o),
        .sel_o        (sel_o),
        .padr_o       (padr_o),
        .ack_i        (ack_i),
        .inv_all_i    (inv_all_i),
        .inv_asid_i   (inv_asid_i),
        .inv_asid_v_i (inv_asid_v_i)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [51:0] mkva(input logic [7:0] asid,
                                         input logic [31:0] a);
        return {asid, 12'h000, a};
    endfunction

    task automatic issue(input logic [51:0] va,
                         input logic w, input logic ic);
        vadr_i = va;
        we_i   = w;
        icl_i  = ic;
        sel_i  = 8'hFF;
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        @(negedge clk);
    endtask

    task automatic drop();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        icl_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic walk_rsp(input logic [31:0] pa,
                            input logic [3:0] p,
                            input logic f);
        walk_padr_i  = pa;
        walk_drwx_i  = p;
        walk_fault_i = f;
        walk_done_i  = 1'b1;
        @(negedge clk);
        walk_done_i  = 1'b0;
        walk_fault_i = 1'b0;
    endtask

    task automatic bus_end(input string tag,
                           input logic [31:0] pa);
        int n = 0;
        while (!cyc_o && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cyc"}, cyc_o, 1);
        chk({tag, "_padr"}, padr_o, pa);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        chk({tag, "_ack"}, {ack_o, cyc_o}, 2'b10);
    endtask

    task automatic fill_page(input string tag,
                             input logic [51:0] va,
                             input logic [31:0] pa);
        issue(va, 1'b0, 1'b0);
        chk({tag, "_walk"}, walk_req_o, 1);
        walk_rsp(pa, 4'b0110, 1'b0);
        bus_end(tag, {pa[31:13], va[12:0]});
        drop();
    endtask

    task automatic hit_page(input string tag,
                            input logic [51:0] va,
                            input logic [31:0] pa);
        issue(va, 1'b0, 1'b0);
        chk({tag, "_hit"}, {cyc_o, walk_req_o}, 2'b10);
        bus_end(tag, pa);
        drop();
    endtask

    task automatic miss_probe(input string tag,
                              input logic [51:0] va);
        issue(va, 1'b0, 1'b0);
        chk({tag, "_miss"}, {cyc_o, walk_req_o}, 2'b01);
        walk_rsp(32'h0, 4'h0, 1'b1);
        drop();
    endtask

    initial begin
        logic [51:0] va1, va2, va3, va4, va5, va6;
        rst = 1'b1;
        {cyc_i, stb_i, we_i, icl_i, ack_i} = '0;
        {walk_done_i, walk_fault_i} = '0;
        {inv_all_i, inv_asid_i} = '0;
        inv_asid_v_i = '0;
        ol_i = 2'd0;
        sel_i = '0;
        vadr_i = '0;
        walk_padr_i = '0;
        walk_drwx_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", outs, 9'h0);
        chk("rst_padr", padr_o, 32'h0);
        chk("rst_wva", walk_vadr_o, 52'h0);
        rst = 1'b0;
        @(negedge clk);

        ol_i = 2'd0;
        issue(52'h0_0012_3456, 1'b0, 1'b0);
        chk("byp_nowalk", {cyc_o, walk_req_o}, 2'b10);
        bus_end("byp", 32'h0012_3456);
        drop();
        ol_i = 2'd3;
        hit_page("bypff", mkva(8'h05, 32'hFF00_1234),
                 32'hFF00_1234);

        va1 = mkva(8'h05, 32'h1000_2010);
        issue(va1, 1'b0, 1'b0);
        chk("m1_walk", {cyc_o, walk_req_o}, 2'b01);
        chk("m1_wva", walk_vadr_o, va1);
        @(negedge clk);
        chk("m1_hold", walk_vadr_o, va1);
        walk_rsp(32'h0004_A000, 4'b0110, 1'b0);
        chk("m1_lat", cyc_o, 0);
        @(negedge clk);
        chk("m1_lat2", cyc_o, 1);
        bus_end("m1", 32'h0004_A010);
        drop();
        hit_page("h1", va1, 32'h0004_A010);

        va2 = mkva(8'h05, 32'h2000_4008);
        issue(va2, 1'b1, 1'b0);
        chk("wv_walk", walk_req_o, 1);
        walk_rsp(32'h0008_0000, 4'b0100, 1'b0);
        @(negedge clk);
        chk("wv_flags", outs, 9'b110100000);
        @(negedge clk);
        chk("wv_clear", outs, 9'b000000000);
        drop();
        issue(va2, 1'b0, 1'b1);
        chk("xv_flags", outs, 9'b110010000);
        drop();
        hit_page("rd2", va2, 32'h0008_0008);

        va3 = mkva(8'h05, 32'h3000_0000);
        issue(va3, 1'b0, 1'b0);
        walk_rsp(32'h0, 4'h0, 1'b1);
        chk("pf_flags", outs, 9'b110001000);
        @(negedge clk);
        chk("pf_pulse", outs, 9'b000000000);
        drop();
        miss_probe("pf_nofill", va3);

        va4 = mkva(8'h09, 32'h5000_6004);
        issue(va4, 1'b0, 1'b0);
        chk("iw_walk", walk_req_o, 1);
        inv_all_i = 1'b1;
        walk_rsp(32'h0123_4000, 4'b0110, 1'b0);
        inv_all_i = 1'b0;
        bus_end("iw", 32'h0123_4004);
        drop();
        miss_probe("iw_nofill", va4);
        miss_probe("iw_flush", va1);

        va5 = mkva(8'h05, 32'h6000_0000);
        issue(va5, 1'b0, 1'b0);
        chk("rw_walk", walk_req_o, 1);
        rst = 1'b1;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(negedge clk);
        chk("rw_outs", outs, 9'h0);
        chk("rw_wva", walk_vadr_o, 52'h0);
        rst = 1'b0;
        walk_rsp(32'h0070_0000, 4'b0110, 1'b0);
        chk("rw_late", outs, 9'h0);
        miss_probe("rw_nofill", va5);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            fill_page("ev_fill",
                      mkva(8'h05, 32'h4000_0000 + (k << 13)),
                      32'h0100_0000 + (k << 13));
        end
        hit_page("ev_p1", mkva(8'h05, 32'h4000_2000),
                 32'h0100_2000);
        fill_page("ev_p0", mkva(8'h05, 32'h4000_0000),
                  32'h0100_0000);
        miss_probe("ev_rr1", mkva(8'h05, 32'h4000_2000));
        hit_page("ev_p2", mkva(8'h05, 32'h4000_4000),
                 32'h0100_4000);
        va6 = mkva(8'h06, 32'h4000_0000);
        fill_page("ev_a6", va6, 32'h0200_0000);
        hit_page("ev_p8", mkva(8'h05, 32'h4001_0000),
                 32'h0101_0000);

        inv_asid_i = 1'b1;
        inv_asid_v_i = 8'h05;
        @(negedge clk);
        inv_asid_i = 1'b0;
        miss_probe("ia_p8", mkva(8'h05, 32'h4001_0000));
        miss_probe("ia_p3", mkva(8'h05, 32'h4000_6000));
        hit_page("ia_a6", va6, 32'h0200_0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
